// File: rtl/fetch_stage.sv
// IF stage with IF/ID pipeline register: owns the PC, drives a 1-cycle synchronous
// instruction memory, and keeps a one-entry hold buffer so stalls never lose a fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        PCWrite,
  input  logic        FDWrite,
  input  logic        BrTaken_E,
  input  logic [31:0] BrTarget_E,
  output logic [31:0] IADDR,
  output logic        IREN,
  input  logic [31:0] IRDATA,
  output logic [31:0] PC_F,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic        Valid_D
);

  // State encoding is {InFlightValid, HoldValid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RUN   = 2'b10,
    HELD  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_d_q, ir_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        valid_d_q, valid_d_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] hold_ir_q, hold_ir_d;

  logic        inflight_valid;
  logic        hold_valid;
  logic [31:0] sel_ir;
  logic        unused_tgt_lsbs;

  assign inflight_valid  = state_q[1];
  assign hold_valid      = state_q[0];
  assign sel_ir          = hold_valid ? hold_ir_q : IRDATA;
  assign unused_tgt_lsbs = ^BrTarget_E[1:0];

  assign IADDR   = pc_q;
  assign IREN    = RSTN & PCWrite;
  assign PC_F    = pc_q;
  assign IR_D    = ir_d_q;
  assign PC_D    = pc_d_q;
  assign Valid_D = valid_d_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= EMPTY;
      pc_q          <= RESET_PC;
      ir_d_q        <= NOP_INSTR;
      pc_d_q        <= 32'h0;
      valid_d_q     <= 1'b0;
      inflight_pc_q <= 32'h0;
      hold_ir_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_d_q        <= ir_d_d;
      pc_d_q        <= pc_d_d;
      valid_d_q     <= valid_d_d;
      inflight_pc_q <= inflight_pc_d;
      hold_ir_q     <= hold_ir_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d_d        = ir_d_q;
    pc_d_d        = pc_d_q;
    valid_d_d     = valid_d_q;
    inflight_pc_d = inflight_pc_q;
    hold_ir_d     = hold_ir_q;

    if (BrTaken_E) begin
      // Redirect beats any stall; the read issued this cycle is simply never consumed.
      pc_d      = {BrTarget_E[31:2], 2'b00};
      ir_d_d    = NOP_INSTR;
      valid_d_d = 1'b0;
      state_d   = EMPTY;
    end else if (PCWrite && FDWrite) begin
      ir_d_d        = inflight_valid ? sel_ir : NOP_INSTR;
      pc_d_d        = inflight_pc_q;
      valid_d_d     = inflight_valid;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 32'd4;
      state_d       = RUN;
    end else begin
      // Stall (mismatched write enables are treated the same way). Only the first
      // stall cycle sees fresh memory data, so capture exactly once.
      case (state_q)
        RUN: begin
          hold_ir_d = IRDATA;
          state_d   = HELD;
        end
        HELD:    state_d = HELD;
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/release, redirect,
// redirect-during-stall, PC wrap, and asynchronous reset while held.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        PCWrite;
  logic        FDWrite;
  logic        BrTaken_E;
  logic [31:0] BrTarget_E;
  logic [31:0] IADDR;
  logic        IREN;
  logic [31:0] IRDATA;
  logic [31:0] PC_F;
  logic [31:0] IR_D;
  logic [31:0] PC_D;
  logic        Valid_D;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .PCWrite   (PCWrite),
    .FDWrite   (FDWrite),
    .BrTaken_E (BrTaken_E),
    .BrTarget_E(BrTarget_E),
    .IADDR     (IADDR),
    .IREN      (IREN),
    .IRDATA    (IRDATA),
    .PC_F      (PC_F),
    .IR_D      (IR_D),
    .PC_D      (PC_D),
    .Valid_D   (Valid_D)
  );

  always #5 CLK = ~CLK;

  // mem[word i] = 0x1000 + i, 1-cycle synchronous read.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000 + (addr >> 2);
  endfunction

  initial IRDATA = 32'h0;
  always @(posedge CLK) if (IREN) IRDATA <= mem_word(IADDR);

  // Hazard-unit contract: the two write enables only differ under a redirect.
  always @(posedge CLK) begin
    if (RSTN === 1'b1 && BrTaken_E === 1'b0) begin
      assert (PCWrite === FDWrite) else begin
        failures++;
        $error("FAIL stall_ctl_mismatch observed=%b expected=%b", PCWrite, FDWrite);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic v, input logic [31:0] ir,
                       input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, Valid_D}, {31'h0, v});
    chk({tag, "_ir"}, IR_D, ir);
    chk({tag, "_pc"}, PC_D, pc);
  endtask

  initial begin
    RSTN       = 1'b0;
    PCWrite    = 1'b1;
    FDWrite    = 1'b1;
    BrTaken_E  = 1'b0;
    BrTarget_E = 32'h0;
    #12;
    chk("rst_pcf", PC_F, 32'h0);
    chk("rst_iren", {31'h0, IREN}, 32'h0);
    chk_d("rst", 1'b0, 32'h0, 32'h0);

    @(posedge CLK); #1;
    RSTN = 1'b1;
    #1;
    chk("first_iren", {31'h0, IREN}, 32'h1);
    chk("first_iaddr", IADDR, 32'h0);

    tick();  // edge 1
    chk("e1_valid", {31'h0, Valid_D}, 32'h0);
    chk("e1_pcf", PC_F, 32'h4);
    tick();  // edge 2
    chk_d("e2", 1'b1, 32'h1000, 32'h0);
    tick();  // edge 3
    chk_d("e3", 1'b1, 32'h1001, 32'h4);
    tick();  // edge 4
    chk_d("e4", 1'b1, 32'h1002, 32'h8);
    chk("e4_pcf", PC_F, 32'h10);

    // Three-cycle stall with IR_D = 0x1002
    PCWrite = 1'b0;
    FDWrite = 1'b0;
    #1;
    chk("stall_iren", {31'h0, IREN}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_d("stall", 1'b1, 32'h1002, 32'h8);
      chk("stall_pcf", PC_F, 32'h10);
    end
    PCWrite = 1'b1;
    FDWrite = 1'b1;
    tick();
    chk_d("rel1", 1'b1, 32'h1003, 32'hC);
    tick();
    chk_d("rel2", 1'b1, 32'h1004, 32'h10);

    // Taken branch to 0x40 for one cycle
    BrTaken_E  = 1'b1;
    BrTarget_E = 32'h40;
    tick();
    BrTaken_E = 1'b0;
    chk("br_pcf", PC_F, 32'h40);
    chk_d("br1", 1'b0, 32'h0, 32'h10);
    tick();
    chk("br2_valid", {31'h0, Valid_D}, 32'h0);
    tick();
    chk_d("br3", 1'b1, 32'h1010, 32'h40);
    tick();
    chk_d("br4", 1'b1, 32'h1011, 32'h44);

    // Enter HELD, then redirect while still stalled; target LSBs are dropped
    PCWrite = 1'b0;
    FDWrite = 1'b0;
    tick();
    chk_d("held", 1'b1, 32'h1011, 32'h44);
    BrTaken_E  = 1'b1;
    BrTarget_E = 32'h82;
    tick();
    BrTaken_E = 1'b0;
    PCWrite   = 1'b1;
    FDWrite   = 1'b1;
    chk("brst_pcf", PC_F, 32'h80);
    chk("brst_valid", {31'h0, Valid_D}, 32'h0);
    tick();
    chk("brst2_valid", {31'h0, Valid_D}, 32'h0);
    tick();
    chk_d("brst3", 1'b1, 32'h1020, 32'h80);

    // PC wrap
    BrTaken_E  = 1'b1;
    BrTarget_E = 32'hFFFF_FFFC;
    tick();
    BrTaken_E = 1'b0;
    tick();
    chk("wrap_pcf", PC_F, 32'h0);
    tick();
    chk_d("wrap1", 1'b1, 32'h4000_0FFF, 32'hFFFF_FFFC);
    tick();
    chk_d("wrap2", 1'b1, 32'h1000, 32'h0);

    // Asynchronous reset while HELD
    PCWrite = 1'b0;
    FDWrite = 1'b0;
    tick();
    chk("pre_arst_pcf", PC_F, 32'h8);
    #2;
    PCWrite = 1'b1;
    FDWrite = 1'b1;
    RSTN    = 1'b0;
    #1;
    chk("arst_valid", {31'h0, Valid_D}, 32'h0);
    chk("arst_pcf", PC_F, 32'h0);
    chk("arst_iren", {31'h0, IREN}, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
    chk("post_arst1_valid", {31'h0, Valid_D}, 32'h0);
    tick();
    chk_d("post_arst2", 1'b1, 32'h1000, 32'h0);
    tick();
    chk_d("post_arst3", 1'b1, 32'h1001, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
